// File: rtl/beam_pkg.sv
// Shared types for the beam sensor conditioner: defaults, debounce FSM states and
// the event record queued towards the consumer.
package beam_pkg;

    localparam int unsigned NUM_BEAMS_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIntact      = 2'd0,
        StBreakWait   = 2'd1,
        StBroken      = 2'd2,
        StRestoreWait = 2'd3
    } beam_state_e;

    typedef struct packed {
        logic [1:0] beam;
        logic       on;
    } beam_event_t;

endpackage

// File: rtl/beam_debounce.sv
// One beam: 2-flop synchronizer, debounce FSM and stability counter. fire_o is high in
// the cycle whose closing edge completes a break (fire_on_o=1) or a restore (fire_on_o=0).
module beam_debounce
    import beam_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic enable_i,
    output logic broken_o,
    output logic fire_o,
    output logic fire_on_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    beam_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Synchronizers reset to 1 so a released reset looks like an intact beam.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StIntact;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire_o    = 1'b0;
        fire_on_o = 1'b0;
        if (!enable_i) begin
            state_d = StIntact;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIntact: begin
                    if (!sync2_q) begin
                        state_d = StBreakWait;
                        cnt_d   = '0;
                    end
                end
                StBreakWait: begin
                    if (sync2_q) begin
                        state_d = StIntact;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d   = StBroken;
                        cnt_d     = '0;
                        fire_o    = 1'b1;
                        fire_on_o = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StBroken: begin
                    if (sync2_q) begin
                        state_d = StRestoreWait;
                        cnt_d   = '0;
                    end
                end
                StRestoreWait: begin
                    if (!sync2_q) begin
                        state_d = StBroken;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StIntact;
                        cnt_d   = '0;
                        fire_o  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIntact;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A restore still in its wait window keeps reporting the beam as broken.
    assign broken_o = enable_i && ((state_q == StBroken) || (state_q == StRestoreWait));

endmodule

// File: rtl/beam_sensor_conditioner.sv
// Debounces NUM_BEAMS photodiode inputs and queues note-on/note-off events through
// per-beam pending slots, a lowest-index-first arbiter and a small FIFO.
module beam_sensor_conditioner
    import beam_pkg::*;
#(
    parameter int unsigned NUM_BEAMS       = NUM_BEAMS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [NUM_BEAMS-1:0] beam_raw,
    input  logic [NUM_BEAMS-1:0] beam_enable,
    output logic [NUM_BEAMS-1:0] beam_broken,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [1:0]           event_beam,
    output logic                 event_on,
    output logic                 overflow,
    input  logic                 overflow_clear
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [NUM_BEAMS-1:0] fire, fire_on;
    logic [NUM_BEAMS-1:0] pending_q, pending_d;
    logic [NUM_BEAMS-1:0] pend_on_q, pend_on_d;
    logic [NUM_BEAMS-1:0] grant;
    logic                 overflow_q, overflow_d, ovf_set;
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    beam_event_t          mem_q [FIFO_DEPTH];
    beam_event_t          push_ev, head;
    logic                 empty, full, pop, push;

    for (genvar g = 0; g < NUM_BEAMS; g++) begin : g_beam
        beam_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i    (clk_clk),
            .rst_ni   (reset_reset_n),
            .raw_i    (beam_raw[g]),
            .enable_i (beam_enable[g]),
            .broken_o (beam_broken[g]),
            .fire_o   (fire[g]),
            .fire_on_o(fire_on[g])
        );
    end

    // Lowest set pending bit wins.
    assign grant = pending_q & (~pending_q + NUM_BEAMS'(1));

    always_comb begin
        push_ev = '0;
        for (int i = 0; i < NUM_BEAMS; i++) begin
            if (grant[i]) begin
                push_ev.beam = 2'(i);
                push_ev.on   = pend_on_q[i];
            end
        end
    end

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign event_valid = !empty;
    assign event_beam  = empty ? 2'b00 : head.beam;
    assign event_on    = !empty && head.on;
    assign pop         = event_valid && event_ready;
    assign push        = (|pending_q) && (!full || pop);
    assign overflow    = overflow_q;

    // A slot only overflows if its old event is not leaving on this same edge.
    always_comb begin
        pending_d = pending_q;
        pend_on_d = pend_on_q;
        ovf_set   = 1'b0;
        if (push) begin
            pending_d = pending_q & ~grant;
        end
        for (int i = 0; i < NUM_BEAMS; i++) begin
            if (fire[i]) begin
                if (pending_d[i]) begin
                    ovf_set = 1'b1;
                end
                pending_d[i] = 1'b1;
                pend_on_d[i] = fire_on[i];
            end
        end
        overflow_d = ovf_set || (overflow_q && !overflow_clear);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pending_q  <= '0;
            pend_on_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_on_q  <= pend_on_d;
            overflow_q <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_ev;
        end
    end

endmodule
